// File: rtl/bumpy_motion.sv
// ---------------------------------------------------------------------------
// bumpy_motion
//
// Motion and game-event controller for the Bumpy ball. Once per video frame
// it moves Bumpy under gravity and keyboard control, resolves what happens
// when Bumpy lands on a tile (bounce, coin, brake, spike, teleport, gate),
// keeps the coin count and opens the exit gate once enough coins are held.
//
// Ports:
//   clock_i                clock
//   reset_i                synchronous active-high reset, dominates all inputs
//   startOfFrame_i         one-cycle frame tick (at least 3 cycles apart)
//   left_key_i/right_key_i held keyboard levels
//   lvl_i                  current level; any change restarts the level
//   area_i                 neighbour tile types [0]=left [1]=up [2]=right [3]=down
//   teleport_cordinates_i  teleport destination, [7:4] column, [3:0] row
//   bumpy_x_o/bumpy_y_o    top-left pixel of the 32x32 sprite
//   gate_o                 high once coins >= COINS_FOR_GATE
//   coins_o                coin count, saturating at 15
//   coin_pulse_o           one-cycle strobe when a coin tile is landed on
//   brake_pulse_o          one-cycle strobe when a brake tile is landed on
//   dead_pulse_o           one-cycle strobe on entry to the dead state
//   level_done_o           held high while the level is won
// ---------------------------------------------------------------------------
module bumpy_motion #(
    parameter int SPAWN_X        = 80,
    parameter int SPAWN_Y        = 0,
    parameter int HSPEED         = 2,
    parameter int GRAVITY        = 1,
    parameter int BOUNCE_V       = 12,
    parameter int MAX_VY         = 15,
    parameter int DEAD_FRAMES    = 60,
    parameter int COINS_FOR_GATE = 2
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            startOfFrame_i,
    input  logic            left_key_i,
    input  logic            right_key_i,
    input  logic [2:0]      lvl_i,
    input  logic [3:0][2:0] area_i,
    input  logic [7:0]      teleport_cordinates_i,
    output logic [10:0]     bumpy_x_o,
    output logic [10:0]     bumpy_y_o,
    output logic            gate_o,
    output logic [3:0]      coins_o,
    output logic            coin_pulse_o,
    output logic            brake_pulse_o,
    output logic            dead_pulse_o,
    output logic            level_done_o
);

    // Tile type codes as delivered by the tile/step controller
    localparam logic [2:0] TILE_FREE  = 3'd0;
    localparam logic [2:0] TILE_REGU  = 3'd1;
    localparam logic [2:0] TILE_GATE  = 3'd2;
    localparam logic [2:0] TILE_COIN  = 3'd3;
    localparam logic [2:0] TILE_TPORT = 3'd4;
    localparam logic [2:0] TILE_SPIKE = 3'd5;
    localparam logic [2:0] TILE_BRAKE = 3'd6;

    localparam logic [10:0]       SPAWN_X_C    = 11'(SPAWN_X);
    localparam logic [10:0]       SPAWN_Y_C    = 11'(SPAWN_Y);
    localparam logic [11:0]       HSPEED_C     = 12'(HSPEED);
    localparam logic [11:0]       X_MAX_C      = 12'd608;
    localparam logic signed [8:0] GRAVITY_C    = 9'(GRAVITY);
    localparam logic signed [8:0] MAX_VY_C     = 9'(MAX_VY);
    localparam logic signed [7:0] BOUNCE_C     = 8'(BOUNCE_V);
    localparam logic signed [7:0] BRAKE_C      = 8'(BOUNCE_V / 2);
    localparam logic [4:0]        GATE_COUNT_C = 5'(COINS_FOR_GATE);

    localparam int DEAD_W = (DEAD_FRAMES > 1) ? $clog2(DEAD_FRAMES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST_C = DEAD_W'(DEAD_FRAMES - 1);

    typedef enum logic [2:0] {
        SPAWN,
        AIR,
        LAND,
        TELE,
        DEAD,
        WIN
    } stateT;

    stateT state_q, state_d;

    logic [10:0]       x_q, x_d;
    logic [10:0]       y_q, y_d;
    logic signed [7:0] vy_q, vy_d;
    logic [3:0]        coins_q, coins_d;
    logic              gate_q, gate_d;
    logic [2:0]        lvl_q;
    logic [DEAD_W-1:0] deadCnt_q, deadCnt_d;
    logic [2:0]        landTile_q, landTile_d;
    logic [7:0]        teleDest_q, teleDest_d;
    logic              deadPulse_q, deadPulse_d;

    logic              restart;
    logic              teleValid;
    logic [11:0]       xStep;
    logic [10:0]       xAir;
    logic signed [8:0] vyExt;
    logic signed [8:0] vySum;
    logic signed [7:0] vyGrav;
    logic signed [11:0] yCur;
    logic signed [11:0] vyWide;
    logic signed [11:0] yNext;
    logic [10:0]       yAir;
    logic signed [7:0] vyAir;
    logic              landHit;
    logic              fellOff;

    function automatic logic isSolid(input logic [2:0] tile);
        return tile != TILE_FREE;
    endfunction

    // A level change is detected against the registered copy of lvl_i and
    // overrides whatever transition the state machine had pending.
    assign restart   = (lvl_i != lvl_q);
    assign teleValid = (teleDest_q[7:4] <= 4'd9) &&
                       (teleDest_q[3:0] >= 4'd1) &&
                       (teleDest_q[3:0] <= 4'd6);

    // Horizontal motion for one frame: the key pair gives the direction, a
    // solid neighbour stops the sprite flush against the wall of its cell
    // (offset 32 on the right because the sprite is half a tile wide), and
    // the result is finally clamped to the visible screen.
    always_comb begin
        xStep = {1'b0, x_q};
        if (right_key_i && !left_key_i) begin
            if (isSolid(area_i[2]) && (({6'd0, x_q[5:0]} + HSPEED_C) > 12'd32)) begin
                xStep = {1'b0, x_q[10:6], 6'd32};
            end else begin
                xStep = {1'b0, x_q} + HSPEED_C;
            end
        end else if (left_key_i && !right_key_i) begin
            if (isSolid(area_i[0]) && ({6'd0, x_q[5:0]} < HSPEED_C)) begin
                xStep = {1'b0, x_q[10:6], 6'd0};
            end else if ({1'b0, x_q} < HSPEED_C) begin
                xStep = 12'd0;
            end else begin
                xStep = {1'b0, x_q} - HSPEED_C;
            end
        end
        if (xStep > X_MAX_C) begin
            xStep = X_MAX_C;
        end
        xAir = xStep[10:0];
    end

    // Vertical motion for one frame. Gravity is applied first and saturated,
    // then the candidate position is tested against the screen top, the tile
    // above (only when rising into a new row) and the tile below (when the
    // sprite bottom reaches the lower half of the cell or a lower row).
    // Falling past the bottom row without a landing kills Bumpy; in that
    // case the position is left where it was so the corpse stays on screen.
    always_comb begin
        vyExt   = {vy_q[7], vy_q};
        vySum   = vyExt + GRAVITY_C;
        vyGrav  = (vySum > MAX_VY_C) ? MAX_VY_C[7:0] : vySum[7:0];
        yCur    = {1'b0, y_q};
        vyWide  = {{4{vyGrav[7]}}, vyGrav};
        yNext   = yCur + vyWide;
        yAir    = yNext[10:0];
        vyAir   = vyGrav;
        landHit = 1'b0;
        fellOff = 1'b0;
        if (yNext < 12'sd0) begin
            yAir  = 11'd0;
            vyAir = 8'sd0;
        end else if ((vyGrav < 8'sd0) && (yNext[10:6] < y_q[10:6]) && isSolid(area_i[1])) begin
            yAir  = {y_q[10:6], 6'd0};
            vyAir = 8'sd0;
        end else if ((vyGrav > 8'sd0) &&
                     ((yNext[5:0] >= 6'd32) || (yNext[10:6] > y_q[10:6])) &&
                     isSolid(area_i[3])) begin
            yAir    = {y_q[10:6], 6'd32};
            landHit = 1'b1;
        end else if (yNext > 12'sd416) begin
            yAir    = y_q;
            vyAir   = vy_q;
            fellOff = 1'b1;
        end
    end

    // State register; reset always returns to SPAWN.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= SPAWN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. LAND and TELE are single-cycle states so frame ticks
    // that fall on them are simply not looked at.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SPAWN: state_d = AIR;
            AIR: begin
                if (startOfFrame_i) begin
                    if (landHit) begin
                        state_d = LAND;
                    end else if (fellOff) begin
                        state_d = DEAD;
                    end
                end
            end
            LAND: begin
                case (landTile_q)
                    TILE_SPIKE: state_d = DEAD;
                    TILE_GATE:  state_d = WIN;
                    TILE_TPORT: state_d = teleValid ? TELE : AIR;
                    default:    state_d = AIR;
                endcase
            end
            TELE: state_d = AIR;
            DEAD: begin
                if (startOfFrame_i && (deadCnt_q == DEAD_LAST_C)) begin
                    state_d = SPAWN;
                end
            end
            WIN:     state_d = WIN;
            default: state_d = SPAWN;
        endcase
        if (restart) begin
            state_d = SPAWN;
        end
    end

    // Datapath next-state. Motion is committed only on a frame tick in AIR;
    // the landed tile and teleport destination are latched at that same tick
    // so LAND and TELE work from stable copies. Any path into SPAWN (respawn
    // after death or level restart) reloads the spawn position.
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        vy_d        = vy_q;
        coins_d     = coins_q;
        deadCnt_d   = deadCnt_q;
        landTile_d  = landTile_q;
        teleDest_d  = teleDest_q;
        case (state_q)
            AIR: begin
                if (startOfFrame_i && !fellOff) begin
                    x_d  = xAir;
                    y_d  = yAir;
                    vy_d = vyAir;
                    if (landHit) begin
                        landTile_d = area_i[3];
                        teleDest_d = teleport_cordinates_i;
                    end
                end
            end
            LAND: begin
                case (landTile_q)
                    TILE_REGU: vy_d = -BOUNCE_C;
                    TILE_COIN: begin
                        vy_d = -BOUNCE_C;
                        if (coins_q != 4'd15) begin
                            coins_d = coins_q + 4'd1;
                        end
                    end
                    TILE_BRAKE: vy_d = -BRAKE_C;
                    TILE_TPORT: begin
                        if (!teleValid) begin
                            vy_d = -BOUNCE_C;
                        end
                    end
                    default: ;
                endcase
            end
            TELE: begin
                x_d  = {1'b0, teleDest_q[7:4], 6'd16};
                y_d  = {1'b0, teleDest_q[3:0], 6'd0} - 11'd32;
                vy_d = 8'sd0;
            end
            DEAD: begin
                if (startOfFrame_i) begin
                    deadCnt_d = (deadCnt_q == DEAD_LAST_C) ? '0 : deadCnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        if (state_d == SPAWN) begin
            x_d       = SPAWN_X_C;
            y_d       = SPAWN_Y_C;
            vy_d      = 8'sd0;
            deadCnt_d = '0;
        end
        if (restart) begin
            coins_d = 4'd0;
        end
        gate_d      = ({1'b0, coins_d} >= GATE_COUNT_C) && !restart;
        deadPulse_d = (state_d == DEAD) && (state_q != DEAD);
    end

    // Datapath registers, including the registered copy of the level number
    // used for restart detection.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            x_q         <= SPAWN_X_C;
            y_q         <= SPAWN_Y_C;
            vy_q        <= 8'sd0;
            coins_q     <= 4'd0;
            gate_q      <= 1'b0;
            lvl_q       <= lvl_i;
            deadCnt_q   <= '0;
            landTile_q  <= TILE_FREE;
            teleDest_q  <= 8'd0;
            deadPulse_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            vy_q        <= vy_d;
            coins_q     <= coins_d;
            gate_q      <= gate_d;
            lvl_q       <= lvl_i;
            deadCnt_q   <= deadCnt_d;
            landTile_q  <= landTile_d;
            teleDest_q  <= teleDest_d;
            deadPulse_q <= deadPulse_d;
        end
    end

    // Output decode. Strobes are masked by reset so nothing fires in a reset
    // cycle even if the machine happens to sit in LAND at that moment.
    always_comb begin
        coin_pulse_o  = 1'b0;
        brake_pulse_o = 1'b0;
        level_done_o  = 1'b0;
        dead_pulse_o  = deadPulse_q && !reset_i;
        case (state_q)
            LAND: begin
                coin_pulse_o  = (landTile_q == TILE_COIN) && !reset_i;
                brake_pulse_o = (landTile_q == TILE_BRAKE) && !reset_i;
            end
            WIN:     level_done_o = 1'b1;
            default: ;
        endcase
    end

    assign bumpy_x_o = x_q;
    assign bumpy_y_o = y_q;
    assign coins_o   = coins_q;
    assign gate_o    = gate_q;

endmodule

// File: tb/tb_bumpy_motion.sv
// ---------------------------------------------------------------------------
// tb_bumpy_motion
//
// Frame-level bench for bumpy_motion: every frame is one tick followed by a
// few idle cycles, after which position, coins, gate, level_done and the
// strobes seen during the frame are compared with a frame-level game model.
// ---------------------------------------------------------------------------
module tb_bumpy_motion;

    localparam int HSPEED   = 2;
    localparam int BOUNCE   = 12;
    localparam int MAX_VY   = 15;
    localparam int DEAD_N   = 60;
    localparam int GATE_N   = 2;
    localparam int SPAWN_X  = 80;
    localparam int SPAWN_Y  = 0;

    localparam int MODE_AIR  = 0;
    localparam int MODE_DEAD = 1;
    localparam int MODE_WIN  = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            startOfFrame = 1'b0;
    logic            leftKey = 1'b0;
    logic            rightKey = 1'b0;
    logic [2:0]      lvl = 3'd1;
    logic [3:0][2:0] area = '0;
    logic [7:0]      teleport = 8'd0;
    logic [10:0]     bumpyX;
    logic [10:0]     bumpyY;
    logic            gate;
    logic [3:0]      coins;
    logic            coinPulse;
    logic            brakePulse;
    logic            deadPulse;
    logic            levelDone;

    int total = 0;
    int bad   = 0;

    // Frame-level game model
    int mX, mY, mVy, mCoins, mMode, mDeadTicks;
    int eCoin, eBrake, eDead;
    int cCoin, cBrake, cDead;

    bumpy_motion dut (
        .clock_i               (clock),
        .reset_i               (reset),
        .startOfFrame_i        (startOfFrame),
        .left_key_i            (leftKey),
        .right_key_i           (rightKey),
        .lvl_i                 (lvl),
        .area_i                (area),
        .teleport_cordinates_i (teleport),
        .bumpy_x_o             (bumpyX),
        .bumpy_y_o             (bumpyY),
        .gate_o                (gate),
        .coins_o               (coins),
        .coin_pulse_o          (coinPulse),
        .brake_pulse_o         (brakePulse),
        .dead_pulse_o          (deadPulse),
        .level_done_o          (levelDone)
    );

    // 10 ns clock
    always #5 clock = ~clock;

    // Safety net so the run always ends
    initial begin
        #900000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [11:0] mkArea(input int l, input int u, input int r, input int d);
        return {3'(d), 3'(r), 3'(u), 3'(l)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelSpawn();
        mX = SPAWN_X;
        mY = SPAWN_Y;
        mVy = 0;
        mMode = MODE_AIR;
        mDeadTicks = 0;
    endtask

    // What a landing on a given tile does to the game
    task automatic modelLand(input int tile, input int tp);
        int col, row;
        col = tp / 16;
        row = tp % 16;
        case (tile)
            1: mVy = -BOUNCE;
            3: begin
                mVy = -BOUNCE;
                eCoin = 1;
                if (mCoins < 15) mCoins = mCoins + 1;
            end
            6: begin
                mVy = -(BOUNCE / 2);
                eBrake = 1;
            end
            5: begin
                mMode = MODE_DEAD;
                mDeadTicks = 0;
                eDead = 1;
            end
            2: mMode = MODE_WIN;
            4: begin
                if (col <= 9 && row >= 1 && row <= 6) begin
                    mX = col * 64 + 16;
                    mY = row * 64 - 32;
                    mVy = 0;
                end else begin
                    mVy = -BOUNCE;
                end
            end
            default: ;
        endcase
    endtask

    // One frame of game play from the model's point of view
    task automatic modelFrame(input int l, input int r, input logic [3:0][2:0] a, input int tp);
        int nx, v, yn;
        eCoin = 0;
        eBrake = 0;
        eDead = 0;
        if (mMode == MODE_DEAD) begin
            mDeadTicks++;
            if (mDeadTicks == DEAD_N) modelSpawn();
        end else if (mMode == MODE_AIR) begin
            nx = mX;
            if (r != 0 && l == 0) begin
                if (a[2] != 0 && (mX % 64) + HSPEED > 32) nx = (mX / 64) * 64 + 32;
                else nx = mX + HSPEED;
            end else if (l != 0 && r == 0) begin
                if (a[0] != 0 && (mX % 64) < HSPEED) nx = (mX / 64) * 64;
                else nx = mX - HSPEED;
            end
            if (nx < 0) nx = 0;
            if (nx > 608) nx = 608;
            v = (mVy + 1 > MAX_VY) ? MAX_VY : mVy + 1;
            yn = mY + v;
            if (yn < 0) begin
                mX = nx; mY = 0; mVy = 0;
            end else if (v < 0 && yn / 64 < mY / 64 && a[1] != 0) begin
                mX = nx; mY = (mY / 64) * 64; mVy = 0;
            end else if (v > 0 && ((yn % 64) >= 32 || yn / 64 > mY / 64) && a[3] != 0) begin
                mX = nx; mY = (mY / 64) * 64 + 32; mVy = v;
                modelLand(int'(a[3]), tp);
            end else if (yn > 416) begin
                mMode = MODE_DEAD;
                mDeadTicks = 0;
                eDead = 1;
            end else begin
                mX = nx; mY = yn; mVy = v;
            end
        end
    endtask

    task automatic checkState(input logic withPulses);
        checkOutput("bumpy_x", 32'(bumpyX), 32'(mX));
        checkOutput("bumpy_y", 32'(bumpyY), 32'(mY));
        checkOutput("coins", 32'(coins), 32'(mCoins));
        checkOutput("gate", 32'(gate), (mCoins >= GATE_N) ? 32'd1 : 32'd0);
        checkOutput("level_done", 32'(levelDone), (mMode == MODE_WIN) ? 32'd1 : 32'd0);
        if (withPulses) begin
            checkOutput("coin_pulse_count", 32'(cCoin), 32'(eCoin));
            checkOutput("brake_pulse_count", 32'(cBrake), 32'(eBrake));
            checkOutput("dead_pulse_count", 32'(cDead), 32'(eDead));
        end
    endtask

    // Drive one frame tick with the given inputs and count strobes over the
    // following four cycles, then compare against the model.
    task automatic applyStimulus(input int l, input int r, input logic [3:0][2:0] a, input int tp);
        @(negedge clock);
        leftKey = (l != 0);
        rightKey = (r != 0);
        area = a;
        teleport = 8'(tp);
        startOfFrame = 1'b1;
        cCoin = 0;
        cBrake = 0;
        cDead = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            startOfFrame = 1'b0;
            cCoin += int'(coinPulse);
            cBrake += int'(brakePulse);
            cDead += int'(deadPulse);
        end
        modelFrame(l, r, a, tp);
        checkState(1'b1);
    endtask

    task automatic resetDut();
        @(negedge clock);
        reset = 1'b1;
        startOfFrame = 1'b0;
        leftKey = 1'b0;
        rightKey = 1'b0;
        area = '0;
        teleport = 8'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        modelSpawn();
        mCoins = 0;
    endtask

    task automatic changeLevel();
        @(negedge clock);
        lvl = lvl + 3'd1;
        repeat (3) @(negedge clock);
        modelSpawn();
        mCoins = 0;
        checkState(1'b0);
    endtask

    initial begin
        logic [3:0][2:0] ra;
        int t;

        // Reset state
        resetDut();
        checkOutput("reset_x", 32'(bumpyX), 32'd80);
        checkOutput("reset_y", 32'(bumpyY), 32'd0);
        checkOutput("reset_coins", 32'(coins), 32'd0);
        checkOutput("reset_gate", 32'(gate), 32'd0);
        checkOutput("reset_level_done", 32'(levelDone), 32'd0);
        checkOutput("reset_pulses", {29'd0, coinPulse, brakePulse, deadPulse}, 32'd0);

        // Free fall
        repeat (8) applyStimulus(0, 0, mkArea(0, 0, 0, 0), 0);
        checkOutput("freefall_y", 32'(bumpyY), 32'd36);
        checkOutput("freefall_x", 32'(bumpyX), 32'd80);

        // Regular bounce
        resetDut();
        repeat (7) applyStimulus(0, 0, mkArea(0, 0, 0, 0), 0);
        applyStimulus(0, 0, mkArea(0, 0, 0, 1), 0);
        checkOutput("bounce_land_y", 32'(bumpyY), 32'd32);
        applyStimulus(0, 0, mkArea(0, 0, 0, 0), 0);
        checkOutput("bounce_rise_y", 32'(bumpyY), 32'd21);

        // Two coin landings open the gate; a level change clears it
        resetDut();
        repeat (20) applyStimulus(0, 0, mkArea(0, 0, 0, 3), 0);
        checkOutput("coins_two", 32'(coins), 32'd2);
        checkOutput("gate_open", 32'(gate), 32'd1);
        changeLevel();
        checkOutput("restart_coins", 32'(coins), 32'd0);
        checkOutput("restart_gate", 32'(gate), 32'd0);
        checkOutput("restart_x", 32'(bumpyX), 32'd80);

        // Reset arriving in the LAND cycle of a coin landing fires no strobe
        resetDut();
        repeat (7) applyStimulus(0, 0, mkArea(0, 0, 0, 3), 0);
        @(negedge clock);
        area = mkArea(0, 0, 0, 3);
        startOfFrame = 1'b1;
        @(negedge clock);
        startOfFrame = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("no_strobe_in_reset", 32'(coinPulse), 32'd0);
        resetDut();

        // Wall on the right blocks, free space does not
        repeat (8) applyStimulus(0, 1, mkArea(0, 0, 0, 0), 0);
        checkOutput("wall_start_x", 32'(bumpyX), 32'd96);
        repeat (10) applyStimulus(0, 1, mkArea(0, 0, 1, 0), 0);
        checkOutput("wall_blocked_x", 32'(bumpyX), 32'd96);
        resetDut();
        repeat (18) applyStimulus(0, 1, mkArea(0, 0, 0, 0), 0);
        checkOutput("wall_free_x", 32'(bumpyX), 32'd116);

        // Teleport, valid and invalid destination
        resetDut();
        repeat (8) applyStimulus(0, 0, mkArea(0, 0, 0, 4), 8'h96);
        checkOutput("tele_x", 32'(bumpyX), 32'd592);
        checkOutput("tele_y", 32'(bumpyY), 32'd352);
        resetDut();
        repeat (8) applyStimulus(0, 0, mkArea(0, 0, 0, 4), 8'h90);
        checkOutput("tele_bad_y", 32'(bumpyY), 32'd32);
        applyStimulus(0, 0, mkArea(0, 0, 0, 0), 0);
        checkOutput("tele_bad_rise_y", 32'(bumpyY), 32'd21);

        // Spike death keeps coins, freezes, then respawns
        resetDut();
        repeat (8) applyStimulus(0, 0, mkArea(0, 0, 0, 3), 0);
        repeat (12) applyStimulus(0, 0, mkArea(0, 0, 0, 5), 0);
        repeat (59) applyStimulus(0, 1, mkArea(0, 0, 0, 0), 0);
        checkOutput("dead_frozen_y", 32'(bumpyY), 32'd32);
        applyStimulus(0, 0, mkArea(0, 0, 0, 0), 0);
        checkOutput("respawn_x", 32'(bumpyX), 32'd80);
        checkOutput("respawn_y", 32'(bumpyY), 32'd0);
        checkOutput("dead_keeps_coins", 32'(coins), 32'd1);

        // Gate tile wins the level until lvl changes
        repeat (8) applyStimulus(0, 0, mkArea(0, 0, 0, 2), 0);
        checkOutput("win_level_done", 32'(levelDone), 32'd1);
        repeat (3) applyStimulus(1, 0, mkArea(0, 0, 0, 0), 0);
        checkOutput("win_held", 32'(levelDone), 32'd1);
        changeLevel();
        checkOutput("win_cleared", 32'(levelDone), 32'd0);

        // Randomized play
        for (int f = 0; f < 400; f++) begin
            for (int k = 0; k < 4; k++) begin
                t = int'($urandom_range(0, 13));
                ra[k] = (t > 7) ? 3'd0 : 3'(t);
            end
            applyStimulus(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), ra,
                          int'($urandom_range(0, 255)));
            if ($urandom_range(0, 29) == 0) changeLevel();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
